// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//   Receives raw PS/2 keyboard frames and checks them (start, odd parity, stop,
//   inter-edge timeout). It strips the E0 (extended) and F0 (break) prefixes
//   and presents one key event at a time over a valid/ready handshake. It also
//   tracks a "jump held" level for W (1D) or extended Up-arrow (E0 75).
//
// Ports
//   clk, rst_n           system clock, synchronous active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 lines
//   scan_code[7:0]       scan code of the presented event, prefixes removed
//   key_release          1 = break event, 0 = make event
//   key_ext              1 = event was E0-prefixed
//   key_valid/key_ready  event handshake
//   jump_held            level: W or extended Up currently held
//   frame_err            sticky: start/parity/stop error or timeout abort
//   overflow             sticky: event dropped while the output was still held
//   err_clr              clears frame_err and overflow (a new set wins)
module ps2_key_sequencer #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       key_release,
  output logic       key_ext,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       jump_held,
  output logic       frame_err,
  output logic       overflow,
  input  logic       err_clr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [1:0] D_IDLE    = 2'd0;
  localparam logic [1:0] D_EXT     = 2'd1;
  localparam logic [1:0] D_BRK     = 2'd2;
  localparam logic [1:0] D_EXT_BRK = 2'd3;

  // ---------------------------------------------------------------------------
  // Input synchronisers: [1:0] is the 2-FF synchroniser, [2] the edge stage.
  // ---------------------------------------------------------------------------
  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic       ps2_fall;
  logic       bit_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign ps2_fall = clk_sync[2] & ~clk_sync[1];
  assign bit_in   = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  logic [1:0]       rx_state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_ok;
  logic [CNT_W-1:0] to_cnt;
  logic             byte_strobe;
  logic [7:0]       rx_byte;
  logic             rx_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_ok      <= 1'b0;
      to_cnt      <= '0;
      byte_strobe <= 1'b0;
      rx_byte     <= '0;
      rx_err      <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      rx_err      <= 1'b0;
      if (ps2_fall) begin
        to_cnt <= '0;
        case (rx_state)
          RX_IDLE: begin
            if (!bit_in) begin
              rx_state <= RX_DATA;
              bit_cnt  <= '0;
            end else begin
              rx_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            // odd parity: data bits plus parity bit must contain an odd count of ones
            par_ok   <= ^{shreg, bit_in};
            rx_state <= RX_STOP;
          end
          default: begin
            rx_state <= RX_IDLE;
            if (bit_in && par_ok) begin
              byte_strobe <= 1'b1;
              rx_byte     <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end
        endcase
      end else if (rx_state != RX_IDLE) begin
        if (to_cnt == TO_LAST) begin
          rx_state <= RX_IDLE;
          to_cnt   <= '0;
          rx_err   <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  logic [1:0] d_state;
  logic [1:0] d_next;
  logic       emit;
  logic       emit_rel;
  logic       emit_ext;
  logic       discard;

  assign discard = (rx_byte == 8'hAA) || (rx_byte == 8'hFA) || (rx_byte == 8'hEE) ||
                   (rx_byte == 8'hFE) || (rx_byte == 8'h00) || (rx_byte == 8'hFF);

  always_comb begin
    d_next   = d_state;
    emit     = 1'b0;
    emit_rel = 1'b0;
    emit_ext = 1'b0;
    if (byte_strobe) begin
      case (d_state)
        D_IDLE: begin
          if (rx_byte == 8'hE0)      d_next = D_EXT;
          else if (rx_byte == 8'hF0) d_next = D_BRK;
          else if (!discard)         emit   = 1'b1;
        end
        D_EXT: begin
          if (rx_byte == 8'hF0) begin
            d_next = D_EXT_BRK;
          end else if (rx_byte != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            d_next   = D_IDLE;
          end
        end
        D_BRK: begin
          emit     = 1'b1;
          emit_rel = 1'b1;
          d_next   = D_IDLE;
        end
        default: begin
          emit     = 1'b1;
          emit_rel = 1'b1;
          emit_ext = 1'b1;
          d_next   = D_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register, handshake, held-key tracking, sticky flags
  // ---------------------------------------------------------------------------
  logic w_held;
  logic up_held;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_state     <= D_IDLE;
      scan_code   <= '0;
      key_release <= 1'b0;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      w_held      <= 1'b0;
      up_held     <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      d_state <= d_next;

      if (emit) begin
        if (!key_valid || key_ready) begin
          scan_code   <= rx_byte;
          key_release <= emit_rel;
          key_ext     <= emit_ext;
          key_valid   <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end

      // held-key state follows every emitted event, even one dropped for overflow
      if (emit && (rx_byte == 8'h1D) && !emit_ext) w_held  <= !emit_rel;
      if (emit && (rx_byte == 8'h75) &&  emit_ext) up_held <= !emit_rel;

      if (emit && key_valid && !key_ready) overflow <= 1'b1;
      else if (err_clr)                    overflow <= 1'b0;

      if (rx_err)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  assign jump_held = w_held | up_held;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
module tb_ps2_key_sequencer;

  localparam int HALF = 8;
  localparam int TO   = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       key_release;
  logic       key_ext;
  logic       key_valid;
  logic       key_ready;
  logic       jump_held;
  logic       frame_err;
  logic       overflow;
  logic       err_clr;

  logic       rand_mode = 1'b0;
  logic       dir_ready = 1'b0;
  logic       rnd_ready = 1'b0;

  assign key_ready = rand_mode ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .CLK_HZ(50000000),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .scan_code(scan_code),
    .key_release(key_release),
    .key_ext(key_ext),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .jump_held(jump_held),
    .frame_err(frame_err),
    .overflow(overflow),
    .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] code;
    logic       rel;
    logic       ext;
    logic       jump;
  } ev_t;

  ev_t  evq[$];
  logic m_ext = 1'b0, m_brk = 1'b0;
  logic m_w = 1'b0, m_up = 1'b0;
  logic exp_ferr = 1'b0, exp_ovf = 1'b0;

  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (!m_brk && b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (!m_brk && b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_brk && !m_ext && is_noise(b)) begin
      // ignored
    end else begin
      if (b == 8'h1D && !m_ext) m_w  = !m_brk;
      if (b == 8'h75 &&  m_ext) m_up = !m_brk;
      if (evq.size() != 0) begin
        exp_ovf = 1'b1;
      end else begin
        e.code = b; e.rel = m_brk; e.ext = m_ext; e.jump = m_w | m_up;
        evq.push_back(e);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    evq.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_w = 1'b0; m_up = 1'b0;
    exp_ferr = 1'b0; exp_ovf = 1'b0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par;
    par = ~^b;
    if (kind == 1) par = ~par;
    if (kind == 0) model_byte(b);
    else exp_ferr = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(kind == 2 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    cyc(30);
  endtask

  task automatic accept();
    dir_ready = 1'b1;
    cyc(1);
    dir_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    cyc(1);
  endtask

  task automatic check_zero(input string tag);
    chk8({tag, "_scan"}, scan_code, 8'h00);
    chk1({tag, "_valid"}, key_valid, 1'b0);
    chk1({tag, "_rel"}, key_release, 1'b0);
    chk1({tag, "_ext"}, key_ext, 1'b0);
    chk1({tag, "_jump"}, jump_held, 1'b0);
    chk1({tag, "_ferr"}, frame_err, 1'b0);
    chk1({tag, "_ovf"}, overflow, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    cyc(2);
    check_zero(tag);
    model_reset();
    rst_n = 1'b1;
    cyc(5);
  endtask

  // ---------------- random ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom % 4) != 0;
    end
  end

  // ---------------- compare process ----------------
  logic       prev_hold = 1'b0;
  logic [7:0] prev_code;
  logic       prev_rel, prev_ext;
  ev_t        cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!key_valid || scan_code !== prev_code || key_release !== prev_rel || key_ext !== prev_ext) begin
          errors++;
          $display("FAIL hold_stable actual=%b/%h/%b/%b required=1/%h/%b/%b",
                   key_valid, scan_code, key_release, key_ext, prev_code, prev_rel, prev_ext);
        end
      end
      if (key_valid && key_ready) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual=%h/%b/%b required=none", scan_code, key_release, key_ext);
        end else begin
          cur = evq.pop_front();
          if (scan_code !== cur.code || key_release !== cur.rel || key_ext !== cur.ext || jump_held !== cur.jump) begin
            errors++;
            $display("FAIL event actual=%h/%b/%b/%b required=%h/%b/%b/%b",
                     scan_code, key_release, key_ext, jump_held, cur.code, cur.rel, cur.ext, cur.jump);
          end
        end
      end
      prev_hold = key_valid && !key_ready;
      prev_code = scan_code;
      prev_rel  = key_release;
      prev_ext  = key_ext;
    end
  end

  // ---------------- main stimulus ----------------
  logic [7:0] tbl [14];
  logic [7:0] b;
  int         kind;

  initial begin
    tbl = '{8'h1D, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE,
            8'hFE, 8'h00, 8'hFF, 8'h1C, 8'h45, 8'h16, 8'h29};
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; err_clr = 1'b0;
    cyc(3);
    check_zero("reset");
    rst_n = 1'b1;
    cyc(5);

    // make 1C
    send_frame(8'h1C, 0);
    chk1("t1_valid", key_valid, 1'b1);
    chk8("t1_scan", scan_code, 8'h1C);
    chk1("t1_rel", key_release, 1'b0);
    chk1("t1_ext", key_ext, 1'b0);
    cyc(5);
    chk1("t1_valid_held", key_valid, 1'b1);
    accept();
    chk1("t1_valid_drop", key_valid, 1'b0);

    // extended Up make then break
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    chk8("t2_scan", scan_code, 8'h75);
    chk1("t2_rel", key_release, 1'b0);
    chk1("t2_ext", key_ext, 1'b1);
    chk1("t2_jump", jump_held, 1'b1);
    accept();
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    chk8("t2b_scan", scan_code, 8'h75);
    chk1("t2b_rel", key_release, 1'b1);
    chk1("t2b_ext", key_ext, 1'b1);
    chk1("t2b_jump", jump_held, 1'b0);
    accept();

    // bad parity
    send_frame(8'h16, 1);
    chk1("t3_valid", key_valid, 1'b0);
    chk1("t3_ferr", frame_err, 1'b1);
    pulse_clr();
    chk1("t3_ferr_clr", frame_err, 1'b0);

    // overflow with consumer stalled
    send_frame(8'h45, 0);
    send_frame(8'h16, 0);
    chk1("t4_valid", key_valid, 1'b1);
    chk8("t4_scan", scan_code, 8'h45);
    chk1("t4_ovf", overflow, 1'b1);
    accept();
    chk1("t4_valid_drop", key_valid, 1'b0);
    pulse_clr();
    chk1("t4_ovf_clr", overflow, 1'b0);

    // timeout after 4 data bits
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(TO + 40);
    chk1("t5_ferr", frame_err, 1'b1);
    chk1("t5_valid", key_valid, 1'b0);
    exp_ferr = 1'b1;
    pulse_clr();
    send_frame(8'h1D, 0);
    chk1("t5_valid2", key_valid, 1'b1);
    chk8("t5_scan", scan_code, 8'h1D);
    chk1("t5_jump", jump_held, 1'b1);
    accept();

    // reset mid-frame, then reset while a break prefix is pending
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    do_reset("t6a");
    send_frame(8'hF0, 0);
    do_reset("t6b");
    send_frame(8'h1E, 0);
    chk1("t6_valid", key_valid, 1'b1);
    chk8("t6_scan", scan_code, 8'h1E);
    chk1("t6_rel", key_release, 1'b0);
    accept();

    // randomized traffic
    rand_mode = 1'b1;
    for (int n = 0; n < 120; n++) begin
      b = (($urandom % 8) == 0) ? 8'($urandom) : tbl[$urandom % 14];
      kind = $urandom % 16;
      if (kind == 3) begin
        send_bit(1'b1);
        exp_ferr = 1'b1;
        cyc(30);
      end else begin
        send_frame(b, (kind < 3) ? kind : 0);
      end
      chk1("rnd_ferr", frame_err, exp_ferr);
      chk1("rnd_ovf", overflow, exp_ovf);
      chk1("rnd_jump", jump_held, m_w | m_up);
      if (($urandom % 8) == 0) pulse_clr();
    end
    rand_mode = 1'b0;
    cyc(20);
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", evq.size());
    end
    chk1("end_valid", key_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Receives raw PS/2 keyboard frames, validates them, and strips the E0 (extended) and F0 (break) prefixes.
- Presents one key event at a time as an 8-bit scan code to the combinational scan-code-to-ASCII converter downstream, using a valid/ready handshake.
- Keeps a level "jump_held" status for the game FSM: high while W (1D) or extended Up-arrow (E0 75) is held.

Parameters:
- CLK_HZ, 50000000, system clock frequency; documentation only, no logic depends on it.
- TIMEOUT_CYCLES, 50000, idle clk cycles after which a partial frame is aborted (1 ms at 50 MHz).
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- scan_code  out  8  scan code of the presented event, prefixes removed; feeds the converter's Sin.
- key_release  out  1  1 = break event (F0 seen), 0 = make event.
- key_ext  out  1  1 = event was E0-prefixed.
- key_valid  out  1  event present on scan_code/key_release/key_ext.
- key_ready  in  1  consumer accepts the event.
- jump_held  out  1  level: W or extended Up currently held.
- frame_err  out  1  sticky: parity, start or stop error, or timeout abort.
- overflow  out  1  sticky: event dropped because the holding register was full.
- err_clr  in  1  clears frame_err and overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces all outputs and state to 0 and the FSMs to IDLE. scan_code=8'h00; prefix flags cleared. Reset mid-frame discards the partial frame.
- Input sync: 2-FF synchronisers on ps2_clk and ps2_data, then a 3rd stage for edge detection. A bit is sampled on a synchronised ps2_clk falling edge (prev=1, cur=0) using synchronised ps2_data.
- Receiver FSM, states RX_IDLE, RX_DATA, RX_PARITY, RX_STOP:
  - RX_IDLE: on a falling edge with data=0 (start bit), go to RX_DATA. Data=1 at that edge: stay and set frame_err.
  - RX_DATA: shift 8 bits, LSB first; after the 8th go to RX_PARITY.
  - RX_PARITY: odd parity over the 8 data bits plus the parity bit is required.
  - RX_STOP: the stop bit must be 1. A good frame produces byte_strobe for 1 clk with rx_byte, then RX_IDLE. Bad parity or stop: set frame_err, drop the byte, go to RX_IDLE.
- Timeout: the counter resets on every falling edge and increments while not in RX_IDLE. Reaching TIMEOUT_CYCLES-1 forces RX_IDLE and sets frame_err.
- Decoder FSM, states D_IDLE, D_EXT, D_BRK, D_EXT_BRK, acting on byte_strobe:
  - D_IDLE: E0 -> D_EXT; F0 -> D_BRK; other byte -> emit(make, ext=0).
  - D_EXT: F0 -> D_EXT_BRK; E0 -> stay; other -> emit(make, ext=1), D_IDLE.
  - D_BRK: any byte -> emit(release, ext=0), D_IDLE.
  - D_EXT_BRK: any byte -> emit(release, ext=1), D_IDLE.
  - Bytes AA (BAT), FA (ACK), EE, FE, 00 and FF in D_IDLE are discarded, no emit.
- Emit and handshake:
  - If key_valid=0, or key_valid=1 with key_ready=1 in the same cycle, load the outputs and set key_valid=1 on the next clk.
  - Otherwise drop the event and set overflow.
  - key_valid clears the cycle after key_valid and key_ready are both 1 with no new emit.
  - Outputs stay stable while key_valid=1 and key_ready=0.
  - Latency: key_valid rises 1 clk after the byte_strobe of the final byte.
- jump_held:
  - Set on make of 1D (ext=0) or 75 (ext=1). Cleared on release of the same pair. Kept as two bits, OR-ed.
  - Updated on emit even if the event is dropped for overflow.
  - Not affected by frame errors.
- err_clr: clears the sticky flags next clk. If a set condition occurs in the same cycle, set wins.

Test Plan:
- Reset, then frame 1C (bits LSB first, parity=0, stop=1) -> scan_code=1C, key_release=0, key_ext=0, key_valid=1 until key_ready; converter output is 41.
- Frames E0,75 then E0,F0,75 -> event{75, release=0, ext=1} with jump_held=1, then event{75, release=1, ext=1} with jump_held=0.
- Frame 16 with parity=1 (wrong) -> no key_valid, frame_err=1; err_clr pulse -> frame_err=0.
- key_ready held 0, send make 45 then make 16 -> key_valid stays with scan_code=45, overflow=1; raise key_ready -> key_valid drops 1 clk later.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_err=1, RX_IDLE; a following frame 1D emits normally with jump_held=1.
- Assert rst_n=0 mid-frame and in D_BRK -> all outputs 0; the next frame 1E is treated as make, scan_code=1E.
